// File: rtl/melody_sequencer_if.sv
// Bus bundle between the melody sequencer, its song ROM and the tone generator.
// MELODY_SEQUENCER_TRANSPOSE_EN adds the signed transpose input.
interface melody_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DUR_W  = 8,
    parameter int NOTE_W = 8
);
    // start/stop are single-cycle pulses with no handshake: start is taken only
    // in IDLE, stop is taken in any state and wins over start in the same cycle.
    logic                    start;
    logic                    stop;
    logic                    loop_en;
    logic [ADDR_W-1:0]       start_addr;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DUR_W+NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0]       note;
    logic                    gate;
    logic                    note_strobe;
    logic                    busy;
    logic                    done;
`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
    logic signed [NOTE_W-1:0] transpose;

    modport master (
        input  start, stop, loop_en, start_addr, rom_data, transpose,
        output rom_addr, note, gate, note_strobe, busy, done
    );
    modport slave (
        output start, stop, loop_en, start_addr, rom_data, transpose,
        input  rom_addr, note, gate, note_strobe, busy, done
    );
`else
    modport master (
        input  start, stop, loop_en, start_addr, rom_data,
        output rom_addr, note, gate, note_strobe, busy, done
    );
    modport slave (
        output start, stop, loop_en, start_addr, rom_data,
        input  rom_addr, note, gate, note_strobe, busy, done
    );
`endif
endinterface

// File: rtl/melody_sequencer.sv
// Autonomous melody player: walks a {duration, note} ROM and times each note.
// Optional macro MELODY_SEQUENCER_TRANSPOSE_EN enables saturating transposition.
module melody_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DUR_W    = 8,
    parameter int NOTE_W   = 8,
    parameter int TICK_DIV = 12500000,
    parameter int GAP_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    melody_sequencer_if.master bus,
    output logic [1:0]         dbg_state_o
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] GAP_START = TICK_W'(TICK_DIV - 1 - GAP_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [NOTE_W-1:0]   note_q;
    logic                gate_q;
    logic                strobe_q;
    logic                done_q;
    logic                first_q;
    logic [TICK_W-1:0]   tick_q;
    logic [DUR_W-1:0]    dur_q;

    logic [DUR_W-1:0]    rom_dur;
    logic [NOTE_W-1:0]   rom_note;
    logic [NOTE_W-1:0]   note_d;
    logic                last_unit;

    assign rom_dur   = bus.rom_data[DUR_W+NOTE_W-1:NOTE_W];
    assign rom_note  = bus.rom_data[NOTE_W-1:0];
    assign last_unit = (dur_q == DUR_W'(1));

`ifdef MELODY_SEQUENCER_TRANSPOSE_EN
    localparam logic signed [NOTE_W+1:0] SUM_MIN = (NOTE_W+2)'(1);
    localparam logic signed [NOTE_W+1:0] SUM_MAX = (NOTE_W+2)'((1 << NOTE_W) - 1);
    logic signed [NOTE_W+1:0] note_sum;

    // Two guard bits keep the signed sum exact before clamping to [1, max].
    assign note_sum = $signed({2'b00, rom_note})
                    + $signed({{2{bus.transpose[NOTE_W-1]}}, bus.transpose});

    always_comb begin
        note_d = rom_note;
        if (rom_note != '0) begin
            if (note_sum < SUM_MIN)      note_d = NOTE_W'(1);
            else if (note_sum > SUM_MAX) note_d = '1;
            else                         note_d = note_sum[NOTE_W-1:0];
        end
    end
`else
    assign note_d = rom_note;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            note_q     <= '0;
            gate_q     <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            first_q    <= 1'b0;
            tick_q     <= '0;
            dur_q      <= '0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (bus.stop) begin
                state_q <= ST_IDLE;
                gate_q  <= 1'b0;
                note_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            rom_addr_q <= bus.start_addr;
                            first_q    <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        gate_q  <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (rom_dur == '0) begin
                            // A marker on the very first entry never loops.
                            if (bus.loop_en && !first_q) begin
                                rom_addr_q <= bus.start_addr;
                                state_q    <= ST_FETCH;
                            end else begin
                                done_q  <= 1'b1;
                                note_q  <= '0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            note_q   <= note_d;
                            gate_q   <= (rom_note != '0);
                            strobe_q <= 1'b1;
                            tick_q   <= '0;
                            dur_q    <= rom_dur;
                            first_q  <= 1'b0;
                            state_q  <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (last_unit && tick_q >= GAP_START) gate_q <= 1'b0;
                        if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            dur_q  <= dur_q - DUR_W'(1);
                            if (last_unit) begin
                                rom_addr_q <= rom_addr_q + ADDR_W'(1);
                                state_q    <= ST_FETCH;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.note        = note_q;
    assign bus.gate        = gate_q;
    assign bus.note_strobe = strobe_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign dbg_state_o     = state_q;
endmodule
